path_sequencer: RTL and testbench
=================================

# path_sequencer

Mission-level step sequencer that sits directly upstream of the navigation stage. It holds a small programmable table of path steps, each a command, a path code and a compare distance. It issues one step at a time on COMMAND/PATH/COMPARE_DISTANCE/RUN_FLAG and advances when navigation pulses NEXT_FLAG. It also pauses the mission when DISTANCE_FRONT reports an obstacle, and faults if a step never completes.

## Interface
- DEPTH, 16: number of step-table entries (power of two, 2..64).
- STOP_DIST, 8'd10: DISTANCE_FRONT strictly below this value pauses the mission.
- CLEAR_CYCLES, 24'd10_000_000: consecutive clear cycles required to resume (100 ms at 100 MHz).
- TIMEOUT_CYCLES, 32'd1_000_000_000: maximum cycles in one step before fault.

Ports:
- CLK  in  1  system clock (100 MHz).
- RST  in  1  reset. Asynchronous, active-high.
- START  in  1  single-cycle pulse. Begins the program at step 0 (accepted only in IDLE or DONE).
- ABORT  in  1  single-cycle pulse. Returns to IDLE from any state.
- WR_EN  in  1  step-table write strobe (ignored unless IDLE).
- WR_ADDR  in  log2(DEPTH)  table address.
- WR_DATA  in  21  {command[20:16], path[15:8], compare_distance[7:0]}.
- NEXT_FLAG  in  1  step-complete from navigation; rising edge is the event.
- DISTANCE_FRONT  in  8  debounced front range from navigation.
- COMMAND  out  5  current command; 5'd0 means stop.
- PATH  out  8  current path code.
- COMPARE_DISTANCE  out  8  current step target distance.
- RUN_FLAG  out  2  00 idle, 01 run, 10 paused, 11 done/fault.
- STEP_IDX  out  log2(DEPTH)  index of the step being executed.
- FAULT  out  1  sticky timeout indicator, cleared by START or ABORT.

## Operation
- Table: DEPTH×21 registers, written synchronously on WR_EN in IDLE. Not cleared by RST.
- An entry with command==0 is end-of-program.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
  - IDLE: outputs zero/00. START → LOAD with idx=0, FAULT=0.
  - LOAD: read table[idx].
    - If command==0 → DONE.
    - Else latch the step onto the outputs, clear the step timer → RUN.
  - RUN: RUN_FLAG=01, timer counts.
    - NEXT_FLAG rising edge → idx+1. If idx==DEPTH-1 → DONE, else → LOAD.
    - DISTANCE_FRONT<STOP_DIST → PAUSE.
    - Timer reaching TIMEOUT_CYCLES-1 → FAULT=1, DONE.
  - PAUSE: COMMAND forced to 0; PATH and COMPARE_DISTANCE held; RUN_FLAG=10; step timer frozen.
    - Clear counter increments while DISTANCE_FRONT>=STOP_DIST and resets to 0 otherwise.
    - Counter reaching CLEAR_CYCLES → restore latched command, RUN.
    - NEXT_FLAG edges in PAUSE are ignored.
  - DONE: COMMAND=0, RUN_FLAG=11. START → LOAD at step 0.
- ABORT takes priority over every transition → IDLE, outputs zeroed. FAULT is cleared.
- NEXT_FLAG edge detect uses a registered previous value. An edge and an obstacle in the same RUN cycle: the advance wins, and the obstacle is evaluated in the next RUN cycle.

## Timing
- Reset values: COMMAND=0, PATH=0, COMPARE_DISTANCE=0, RUN_FLAG=00, STEP_IDX=0, FAULT=0, state IDLE, all counters 0.
- START to first step on outputs with RUN_FLAG=01: 2 cycles (START→LOAD, LOAD→RUN registered).
- NEXT_FLAG rise to next step on outputs: 3 cycles (edge register, advance, LOAD).
- Obstacle sample to COMMAND=0: 1 cycle.
- Resume: COMMAND restored on the cycle after the clear counter hits CLEAR_CYCLES.
- All outputs are registered; no combinational input-to-output paths.
- RST mid-mission returns to IDLE immediately; table contents are retained.

## Structure
- Shared package/include holds:
  - RUN_FLAG encodings (RF_IDLE, RF_RUN, RF_PAUSE, RF_DONE).
  - CMD_STOP=5'd0.
  - Step field bit positions.
  - State encodings.
- One natural sub-module, obstacle_guard: takes DISTANCE_FRONT and STOP_DIST, produces a blocked level and a clear-for-CLEAR_CYCLES pulse, and contains the clear counter.

## Test plan
Bench uses CLEAR_CYCLES=4 and TIMEOUT_CYCLES=50.
- Program {01,0x10,0x20},{02,0x11,0x30},{00,..}; START; two NEXT_FLAG pulses → COMMAND goes 1 then 2 then 0, RUN_FLAG ends at 11, STEP_IDX=2, FAULT=0.
- While running step 0, drive DISTANCE_FRONT=5 for 3 cycles, then 20 → RUN_FLAG=10 and COMMAND=0 one cycle after the drop. Resumes with COMMAND=1 after 4 clear cycles; a dip to 5 after 2 clear cycles restarts the count.
- Hold NEXT_FLAG high for 10 cycles → exactly one advance.
- No NEXT_FLAG for 50 cycles → FAULT=1, RUN_FLAG=11, COMMAND=0; START clears FAULT and reruns from step 0.
- Full 16-entry table with no stop marker, 16 pulses → DONE after step 15, with no wrap to step 0.
- ABORT during PAUSE, then RST during RUN → both give IDLE with all outputs 0. Table is intact on a later START; WR_EN while running leaves the table unchanged.

Source files
------------

// File: rtl/path_sequencer_pkg.sv
// Shared encodings and step-table layout for the path sequencer.
package path_sequencer_pkg;

  localparam int unsigned CMD_W  = 5;
  localparam int unsigned PATH_W = 8;
  localparam int unsigned DIST_W = 8;
  localparam int unsigned STEP_W = CMD_W + PATH_W + DIST_W;

  // Field positions inside one 21-bit table word
  localparam int unsigned DIST_LSB = 0;
  localparam int unsigned PATH_LSB = DIST_LSB + DIST_W;
  localparam int unsigned CMD_LSB  = PATH_LSB + PATH_W;

  // RUN_FLAG encodings
  localparam logic [1:0] RF_IDLE  = 2'b00;
  localparam logic [1:0] RF_RUN   = 2'b01;
  localparam logic [1:0] RF_PAUSE = 2'b10;
  localparam logic [1:0] RF_DONE  = 2'b11;

  // Command value that marks end-of-program and means "stop" on the output
  localparam logic [CMD_W-1:0] CMD_STOP = 5'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [CMD_W-1:0]  command;
    logic [PATH_W-1:0] path;
    logic [DIST_W-1:0] compare_distance;
  } step_t;

  // Split a raw table word into its fields
  function automatic step_t decode_step(input logic [STEP_W-1:0] raw);
    step_t s;
    s.command          = raw[CMD_LSB  +: CMD_W];
    s.path             = raw[PATH_LSB +: PATH_W];
    s.compare_distance = raw[DIST_LSB +: DIST_W];
    return s;
  endfunction

endpackage

// File: rtl/path_sequencer_obstacle_guard.sv
// Front-obstacle guard: blocked level plus a pulse once the path has stayed
// clear for CLEAR_CYCLES consecutive cycles while enabled.
module path_sequencer_obstacle_guard
  import path_sequencer_pkg::*;
#(
  parameter logic [23:0] CLEAR_CYCLES = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIST_W-1:0] distance,
  input  logic [DIST_W-1:0] stop_dist,
  output logic              blocked_c,
  output logic              clear_pulse_c
);

  localparam int unsigned CNT_W = 24;

  logic [CNT_W-1:0] clear_cnt;

  assign blocked_c     = distance < stop_dist;
  assign clear_pulse_c = enable && (clear_cnt == CLEAR_CYCLES);

  // Count consecutive clear samples; any obstacle, idle period or resume restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_cnt <= '0;
    end else if (!enable || blocked_c || clear_pulse_c) begin
      clear_cnt <= '0;
    end else begin
      clear_cnt <= clear_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/path_sequencer.sv
// Mission step sequencer: issues one table step at a time to navigation,
// advances on NEXT_FLAG, pauses on front obstacles, faults on step timeout.
module path_sequencer
  import path_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter logic [7:0]  STOP_DIST      = 8'd10,
  parameter logic [23:0] CLEAR_CYCLES   = 24'd10_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic              WR_EN,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic [STEP_W-1:0] WR_DATA,
  input  logic              NEXT_FLAG,
  input  logic [DIST_W-1:0] DISTANCE_FRONT,
  output logic [CMD_W-1:0]  COMMAND,
  output logic [PATH_W-1:0] PATH,
  output logic [DIST_W-1:0] COMPARE_DISTANCE,
  output logic [1:0]        RUN_FLAG,
  output logic [AW-1:0]     STEP_IDX,
  output logic              FAULT
);

  localparam logic [AW-1:0] LAST_IDX    = AW'(DEPTH - 1);
  localparam logic [31:0]   TIMER_LIMIT = TIMEOUT_CYCLES - 32'd1;

  logic [STEP_W-1:0] step_table [DEPTH];

  state_t            state;
  logic [AW-1:0]     idx;
  logic [CMD_W-1:0]  cmd_hold;
  logic [31:0]       step_timer;
  logic              next_prev;
  logic              next_rise;
  logic              pausing_c;
  logic              blocked_c;
  logic              clear_pulse_c;
  step_t             cur_step;

  assign cur_step  = decode_step(step_table[idx]);
  assign pausing_c = (state == ST_PAUSE);
  assign STEP_IDX  = idx;

  path_sequencer_obstacle_guard #(
    .CLEAR_CYCLES (CLEAR_CYCLES)
  ) u_guard (
    .clk           (CLK),
    .rst           (RST),
    .enable        (pausing_c),
    .distance      (DISTANCE_FRONT),
    .stop_dist     (STOP_DIST),
    .blocked_c     (blocked_c),
    .clear_pulse_c (clear_pulse_c)
  );

  // Step table: writable only while idle, deliberately not cleared by reset
  always_ff @(posedge CLK) begin
    if (WR_EN && (state == ST_IDLE)) begin
      step_table[WR_ADDR] <= WR_DATA;
    end
  end

  // Registered rising-edge detect on NEXT_FLAG; a held-high flag gives one event
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      next_prev <= 1'b0;
      next_rise <= 1'b0;
    end else begin
      next_prev <= NEXT_FLAG;
      next_rise <= NEXT_FLAG & ~next_prev;
    end
  end

  // Sequencer FSM with registered outputs; ABORT overrides every transition
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= ST_IDLE;
      idx              <= '0;
      cmd_hold         <= CMD_STOP;
      step_timer       <= '0;
      COMMAND          <= CMD_STOP;
      PATH             <= '0;
      COMPARE_DISTANCE <= '0;
      RUN_FLAG         <= RF_IDLE;
      FAULT            <= 1'b0;
    end else if (ABORT) begin
      state            <= ST_IDLE;
      idx              <= '0;
      cmd_hold         <= CMD_STOP;
      step_timer       <= '0;
      COMMAND          <= CMD_STOP;
      PATH             <= '0;
      COMPARE_DISTANCE <= '0;
      RUN_FLAG         <= RF_IDLE;
      FAULT            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state <= ST_LOAD;
            idx   <= '0;
            FAULT <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (cur_step.command == CMD_STOP) begin
            state    <= ST_DONE;
            COMMAND  <= CMD_STOP;
            RUN_FLAG <= RF_DONE;
          end else begin
            state            <= ST_RUN;
            cmd_hold         <= cur_step.command;
            COMMAND          <= cur_step.command;
            PATH             <= cur_step.path;
            COMPARE_DISTANCE <= cur_step.compare_distance;
            RUN_FLAG         <= RF_RUN;
            step_timer       <= '0;
          end
        end

        ST_RUN: begin
          if (next_rise) begin
            // Advance beats an obstacle seen in the same cycle
            if (idx == LAST_IDX) begin
              state    <= ST_DONE;
              COMMAND  <= CMD_STOP;
              RUN_FLAG <= RF_DONE;
            end else begin
              idx   <= idx + AW'(1);
              state <= ST_LOAD;
            end
          end else if (step_timer == TIMER_LIMIT) begin
            state    <= ST_DONE;
            FAULT    <= 1'b1;
            COMMAND  <= CMD_STOP;
            RUN_FLAG <= RF_DONE;
          end else begin
            step_timer <= step_timer + 32'd1;
            if (blocked_c) begin
              state    <= ST_PAUSE;
              COMMAND  <= CMD_STOP;
              RUN_FLAG <= RF_PAUSE;
            end
          end
        end

        ST_PAUSE: begin
          // Step timer frozen; NEXT_FLAG events are dropped here
          if (clear_pulse_c) begin
            state    <= ST_RUN;
            COMMAND  <= cmd_hold;
            RUN_FLAG <= RF_RUN;
          end
        end

        default: begin
          state    <= ST_IDLE;
          COMMAND  <= CMD_STOP;
          RUN_FLAG <= RF_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_sequencer.sv
// Self-checking bench for path_sequencer: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the sequencer.
module tb_path_sequencer;

  localparam int DEPTH   = 16;
  localparam int STOP    = 10;
  localparam int CLEAR   = 4;
  localparam int TIMEOUT = 50;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        ABORT;
  logic        WR_EN;
  logic [3:0]  WR_ADDR;
  logic [20:0] WR_DATA;
  logic        NEXT_FLAG;
  logic [7:0]  DISTANCE_FRONT;
  logic [4:0]  COMMAND;
  logic [7:0]  PATH;
  logic [7:0]  COMPARE_DISTANCE;
  logic [1:0]  RUN_FLAG;
  logic [3:0]  STEP_IDX;
  logic        FAULT;

  int n_checks = 0;
  int n_pass   = 0;

  path_sequencer #(
    .DEPTH          (DEPTH),
    .STOP_DIST      (8'd10),
    .CLEAR_CYCLES   (24'd4),
    .TIMEOUT_CYCLES (32'd50)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .START            (START),
    .ABORT            (ABORT),
    .WR_EN            (WR_EN),
    .WR_ADDR          (WR_ADDR),
    .WR_DATA          (WR_DATA),
    .NEXT_FLAG        (NEXT_FLAG),
    .DISTANCE_FRONT   (DISTANCE_FRONT),
    .COMMAND          (COMMAND),
    .PATH             (PATH),
    .COMPARE_DISTANCE (COMPARE_DISTANCE),
    .RUN_FLAG         (RUN_FLAG),
    .STEP_IDX         (STEP_IDX),
    .FAULT            (FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 fetching a step, 2 executing, 3 held by obstacle, 4 finished
  logic [20:0] ref_tab [DEPTH];
  int          ref_ph;
  int          ref_idx;
  int          ref_age;          // run cycles spent on the current step
  int          ref_clear;        // consecutive clear samples while held
  bit          ref_fault;
  bit          ref_prev_next;
  bit          ref_rise;         // rise seen on the previous edge
  logic [20:0] ref_step;         // step most recently placed on the outputs
  logic [1:0]  ref_fetch_rf;     // run flag visible while fetching
  bit          ref_fetch_cmd;    // fetch follows an executing step

  task automatic ref_tick();
    bit rose_seen;
    if (RST) begin
      ref_ph = 0; ref_idx = 0; ref_age = 0; ref_clear = 0; ref_fault = 0;
      ref_prev_next = 0; ref_rise = 0; ref_step = '0;
      ref_fetch_rf = 2'd0; ref_fetch_cmd = 0;
      return;
    end
    rose_seen     = ref_rise;
    ref_rise      = NEXT_FLAG && !ref_prev_next;
    ref_prev_next = NEXT_FLAG;
    if (WR_EN && ref_ph == 0) ref_tab[WR_ADDR] = WR_DATA;
    if (ABORT) begin
      ref_ph = 0; ref_idx = 0; ref_fault = 0; ref_step = '0;
      return;
    end
    case (ref_ph)
      0, 4: if (START) begin
        ref_fetch_rf  = (ref_ph == 0) ? 2'd0 : 2'd3;
        ref_fetch_cmd = 0;
        ref_ph = 1; ref_idx = 0; ref_fault = 0;
      end
      1: if (ref_tab[ref_idx][20:16] == 5'd0) ref_ph = 4;
         else begin ref_step = ref_tab[ref_idx]; ref_age = 0; ref_ph = 2; end
      2: if (rose_seen) begin
           if (ref_idx == DEPTH - 1) ref_ph = 4;
           else begin ref_idx++; ref_ph = 1; ref_fetch_rf = 2'd1; ref_fetch_cmd = 1; end
         end else if (ref_age == TIMEOUT - 1) begin
           ref_fault = 1; ref_ph = 4;
         end else begin
           ref_age++;
           if (DISTANCE_FRONT < 8'(STOP)) begin ref_ph = 3; ref_clear = 0; end
         end
      3: if (ref_clear == CLEAR) ref_ph = 2;
         else ref_clear = (DISTANCE_FRONT >= 8'(STOP)) ? ref_clear + 1 : 0;
      default: ref_ph = 0;
    endcase
  endtask

  function automatic logic [27:0] ref_outputs();
    logic [4:0] c;
    logic [1:0] rf;
    logic [7:0] p;
    logic [7:0] d;
    p = ref_step[15:8];
    d = ref_step[7:0];
    c = 5'd0;
    case (ref_ph)
      0: begin rf = 2'd0; p = 8'd0; d = 8'd0; end
      1: begin rf = ref_fetch_rf; c = ref_fetch_cmd ? ref_step[20:16] : 5'd0; end
      2: begin rf = 2'd1; c = ref_step[20:16]; end
      3: rf = 2'd2;
      default: rf = 2'd3;
    endcase
    return {ref_fault, 4'(ref_idx), rf, d, p, c};
  endfunction

  always @(posedge CLK) ref_tick();

  function automatic logic [27:0] dut_outputs();
    return {FAULT, STEP_IDX, RUN_FLAG, COMPARE_DISTANCE, PATH, COMMAND};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
    check("outs", 32'(dut_outputs()), 32'(ref_outputs()));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_start();
    START = 1'b1; cycle(); START = 1'b0;
  endtask

  task automatic pulse_abort();
    ABORT = 1'b1; cycle(); ABORT = 1'b0;
  endtask

  task automatic pulse_next();
    NEXT_FLAG = 1'b1; cycle(); NEXT_FLAG = 1'b0;
  endtask

  task automatic write_step(input logic [3:0] a, input logic [20:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d; cycle(); WR_EN = 1'b0;
  endtask

  task automatic wait_rf(input logic [1:0] want, input int budget, input string tag);
    int n;
    n = 0;
    while (RUN_FLAG !== want && n < budget) begin cycle(); n++; end
    check(tag, 32'(RUN_FLAG), 32'(want));
  endtask

  logic [20:0] full_tab [DEPTH];

  initial begin
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; WR_EN = 1'b0;
    WR_ADDR = '0; WR_DATA = '0; NEXT_FLAG = 1'b0; DISTANCE_FRONT = 8'd200;
    run(3);
    check("reset_outs", 32'(dut_outputs()), 32'd0);
    RST = 1'b0;
    run(1);

    // Basic two-step program ending on a stop marker
    write_step(4'd0, {5'd1, 8'h10, 8'h20});
    write_step(4'd1, {5'd2, 8'h11, 8'h30});
    write_step(4'd2, {5'd0, 8'h00, 8'h00});
    pulse_start();
    run(1);
    check("start_cmd", 32'(COMMAND), 32'd1);
    check("start_rf", 32'(RUN_FLAG), 32'd1);
    check("start_path", 32'(PATH), 32'h10);
    pulse_next();
    run(1);
    check("adv_not_yet", 32'(COMMAND), 32'd1);
    run(1);
    check("adv_cmd", 32'(COMMAND), 32'd2);
    check("adv_cd", 32'(COMPARE_DISTANCE), 32'h30);
    pulse_next();
    run(2);
    check("end_cmd", 32'(COMMAND), 32'd0);
    check("end_rf", 32'(RUN_FLAG), 32'd3);
    check("end_idx", 32'(STEP_IDX), 32'd2);
    check("end_fault", 32'(FAULT), 32'd0);

    // Obstacle pause and resume, then a dip that restarts the clear count
    pulse_start();
    run(3);
    DISTANCE_FRONT = 8'd5;
    run(1);
    check("pause_rf", 32'(RUN_FLAG), 32'd2);
    check("pause_cmd", 32'(COMMAND), 32'd0);
    check("pause_path", 32'(PATH), 32'h10);
    run(2);
    DISTANCE_FRONT = 8'd20;
    run(4);
    check("still_paused", 32'(RUN_FLAG), 32'd2);
    run(1);
    check("resume_cmd", 32'(COMMAND), 32'd1);
    check("resume_rf", 32'(RUN_FLAG), 32'd1);
    DISTANCE_FRONT = 8'd5;
    run(1);
    DISTANCE_FRONT = 8'd20;
    run(2);
    DISTANCE_FRONT = 8'd5;
    NEXT_FLAG = 1'b1;
    run(1);
    NEXT_FLAG = 1'b0;
    DISTANCE_FRONT = 8'd20;
    run(4);
    check("dip_paused", 32'(RUN_FLAG), 32'd2);
    run(1);
    check("dip_resume", 32'(COMMAND), 32'd1);
    check("pause_next_ignored", 32'(STEP_IDX), 32'd0);

    // NEXT_FLAG held high gives exactly one advance
    NEXT_FLAG = 1'b1;
    run(10);
    NEXT_FLAG = 1'b0;
    run(3);
    check("hold_idx", 32'(STEP_IDX), 32'd1);
    check("hold_cmd", 32'(COMMAND), 32'd2);

    // Step timeout, then START clears the fault and reruns
    wait_rf(2'd3, 80, "timeout_wait");
    check("timeout_fault", 32'(FAULT), 32'd1);
    check("timeout_cmd", 32'(COMMAND), 32'd0);
    pulse_start();
    check("fault_cleared", 32'(FAULT), 32'd0);
    run(1);
    check("rerun_cmd", 32'(COMMAND), 32'd1);
    check("rerun_idx", 32'(STEP_IDX), 32'd0);

    // ABORT while paused, RST while running, write ignored while running
    DISTANCE_FRONT = 8'd5;
    run(1);
    check("abort_pre", 32'(RUN_FLAG), 32'd2);
    DISTANCE_FRONT = 8'd200;
    pulse_abort();
    check("abort_outs", 32'(dut_outputs()), 32'd0);
    pulse_start();
    run(1);
    write_step(4'd0, {5'd9, 8'hAA, 8'hBB});
    check("run_before_rst", 32'(RUN_FLAG), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_async", 32'(dut_outputs()), 32'd0);
    cycle();
    RST = 1'b0;
    pulse_start();
    run(1);
    check("table_cmd", 32'(COMMAND), 32'd1);
    check("table_path", 32'(PATH), 32'h10);
    check("table_cd", 32'(COMPARE_DISTANCE), 32'h20);

    // Full table without stop marker: ends after the last entry, no wrap
    pulse_abort();
    for (int i = 0; i < DEPTH; i++) begin
      full_tab[i] = {5'($urandom_range(1, 31)), 8'($urandom), 8'($urandom)};
      write_step(4'(i), full_tab[i]);
    end
    pulse_start();
    run(1);
    for (int i = 0; i < DEPTH; i++) begin
      check("full_cmd", 32'(COMMAND), 32'(full_tab[i][20:16]));
      check("full_path", 32'(PATH), 32'(full_tab[i][15:8]));
      check("full_idx", 32'(STEP_IDX), 32'(i));
      pulse_next();
      run(2);
    end
    run(3);
    check("full_rf", 32'(RUN_FLAG), 32'd3);
    check("full_idx_end", 32'(STEP_IDX), 32'd15);
    check("full_cmd_end", 32'(COMMAND), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      START = (r < 15);
      ABORT = (r >= 15 && r < 19);
      RST   = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 7) == 0) NEXT_FLAG = ~NEXT_FLAG;
      DISTANCE_FRONT = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 15))
                                                    : 8'($urandom_range(8, 255));
      WR_EN   = ($urandom_range(0, 30) == 0);
      WR_ADDR = 4'($urandom);
      WR_DATA = 21'($urandom);
      cycle();
    end
    RST = 1'b0; START = 1'b0; ABORT = 1'b0; WR_EN = 1'b0; NEXT_FLAG = 1'b0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
